seq_pattern_tx: RTL
===================

# seq_pattern_tx

Serial frame transmitter for the single-bit `j` link, the sending end of the 10110 sync-detect protocol. On a `start` request it drives the 5-bit sync pattern 10110, MSB first, one bit per clock. It follows with a DATA_W-bit payload, MSB first, and optionally an even-parity bit. It sits upstream of the sync detector and provides frames for the serial-link testbenches.

## Interface
- DATA_W, default 8: payload width in bits, legal range 1–32.
- clk  input  1  rising-edge clock; the block has one clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  frame request, sampled on the rising edge of clk.
- data  input  DATA_W  payload, captured on the accepted start.
- j_out  output  1  serial line, registered; idle level 0.
- busy  output  1  high while a frame is being shifted out.
- done  output  1  one-cycle pulse after the last frame bit.

## Operation
- Moore FSM with states IDLE, SYNC, DATA, PAR and DONE. PAR exists only when the parity feature is compiled in.
- IDLE:
  - j_out=0, busy=0.
  - start=1 at an edge: capture data into the shift register, load SYNC_PATTERN, clear the bit counter, go to SYNC.
- SYNC:
  - j_out = SYNC_PATTERN[4 - cnt].
  - After 5 bits, reload cnt and go to DATA.
- DATA:
  - j_out = shreg MSB; shift left each cycle.
  - After DATA_W bits, go to PAR if parity is enabled, otherwise to DONE.
- PAR:
  - j_out = XOR of the captured payload (even parity over the payload only).
  - Go to DONE.
- DONE:
  - j_out=0, busy=0, done=1 for exactly one cycle.
  - start=1 here is accepted exactly as in IDLE, so frames can run back-to-back with one idle-level gap bit.
  - With no start, go to IDLE.
- busy=1 in SYNC, DATA and PAR; busy=0 in IDLE and DONE.
- start while busy=1 is ignored; data changes while busy=1 have no effect.
- Counter width is $clog2(DATA_W+1), at least 3 bits. It never wraps inside a state because it is reloaded at each state change.
- Reset:
  - Values: state=IDLE, j_out=0, busy=0, done=0, shift register and counter cleared.
  - Asserting reset mid-frame aborts the frame immediately and produces no done pulse.
  - Deasserting reset with start already high: start is accepted on the first edge after deassertion.
- Unused encodings fall back to IDLE.

## Timing
- Accepted start at edge k: j_out = 1 (first sync bit) during cycle k..k+1.
- Bit n of the frame, counting from 0, is valid between edges k+n and k+n+1.
- Frame length L = 5 + DATA_W (+1 with parity).
- done=1 between edges k+L and k+L+1; busy=1 between edges k and k+L.
- All outputs are registered or decoded only from state, with no combinational path from start to any output.

## Configuration
- SEQ_TX_PARITY_EN:
  - Defined: PAR state present; one even-parity bit follows the payload; L = 6 + DATA_W.
  - Undefined: no PAR state or parity logic; DATA goes directly to DONE; L = 5 + DATA_W.

## Structure
- Package seq_tx_pkg holds:
  - the state enum typedef;
  - SYNC_PATTERN = 5'b10110;
  - SYNC_LEN = 5.
- One sub-module, seq_tx_shifter: loadable left-shift register with MSB output, parameterised on width. It is instantiated once for the payload; the sync bits are indexed from the constant.

## Test plan
- Basic frame: reset, then start=1 for one cycle with data=8'hA5, no parity.
  - j_out sequence: 1,0,1,1,0,1,0,1,0,0,1,0,1.
  - busy high for 13 cycles, then done pulses once.
- Parity: with SEQ_TX_PARITY_EN and data=8'h07, the frame ends …0,0,0,0,0,1,1,1 followed by parity bit 1; L=14.
- Ignored start: start held high for the whole frame with data changing after acceptance.
  - The transmitted payload equals the captured value.
  - A second frame starts in the DONE cycle; gap is exactly one 0 bit.
- Reset mid-frame: assert rst during the third DATA bit.
  - j_out=0 and busy=0 immediately.
  - No done pulse.
  - The next start sends a complete frame.
- Loopback: drive j_out into the 10110 sync detector with data=8'hA5.
  - Detector output w pulses exactly once, on the cycle after the fifth sync bit.
  - w stays low for the rest of the frame.
- Width corner: DATA_W=1, data=1'b0 → stream 1,0,1,1,0,0; done at edge k+6.

Source files
------------

// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the 10110 sync-pattern serial frame transmitter.
// The PAR state is only present when SEQ_TX_PARITY_EN is defined.
package seq_tx_pkg;

    localparam int SYNC_LEN = 5;
    localparam logic [SYNC_LEN-1:0] SYNC_PATTERN = 5'b10110;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        DATA = 3'd2,
        DONE = 3'd3
`ifdef SEQ_TX_PARITY_EN
        ,
        PAR  = 3'd4
`endif
    } state_e;

    // Bit counter must hold DATA_W and still index the 5 sync bits.
    function automatic int cnt_width(input int w);
        return ($clog2(w + 1) < 3) ? 3 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// Loadable left-shift register presenting its MSB; carries the frame payload.
module seq_tx_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         shift_i,
    output logic         msb_o
);

    logic [W-1:0] shreg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else if (load_i) begin
            shreg_q <= load_val_i;
        end else if (shift_i) begin
            shreg_q <= shreg_q << 1;
        end
    end

    assign msb_o = shreg_q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: sync pattern 10110, DATA_W-bit payload MSB first,
// and an even-parity bit when SEQ_TX_PARITY_EN is defined. All outputs registered.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              j_out,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             j_out_q;
    logic             busy_q;
    logic             done_q;

    logic             load;
    logic             shift;
    logic             shreg_msb;
    logic [2:0]       sync_idx;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        load     = 1'b0;
        shift    = 1'b0;
        sync_idx = 3'(SYNC_LEN - 2) - cnt_q[2:0];
        case (state_q)
            IDLE, DONE: load  = start;
            SYNC:       shift = (cnt_q == SYNC_LAST);
            DATA:       shift = 1'b1;
            default:    ;
        endcase
    end

    seq_tx_shifter #(
        .W(DATA_W)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .load_val_i (data),
        .shift_i    (shift),
        .msb_o      (shreg_msb)
    );

`ifdef SEQ_TX_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (load) begin
            parity_q <= ^data;
        end
    end
`endif

    // Outputs are computed for the state being entered, so j_out is valid the cycle after the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            j_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads pre-edge register values.
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    j_out_q <= 1'b0;
                    busy_q  <= 1'b0;
                    if (start) begin
                        state_q <= SYNC;
                        j_out_q <= SYNC_PATTERN[SYNC_LEN-1];
                        busy_q  <= 1'b1;
                    end
                end
                SYNC: begin
                    if (cnt_q == SYNC_LAST) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                        j_out_q <= shreg_msb;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        j_out_q <= SYNC_PATTERN[sync_idx];
                    end
                end
                DATA: begin
                    if (cnt_q == DATA_LAST) begin
                        cnt_q <= '0;
`ifdef SEQ_TX_PARITY_EN
                        state_q <= PAR;
                        j_out_q <= parity_q;
`else
                        state_q <= DONE;
                        j_out_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        j_out_q <= shreg_msb;
                    end
                end
`ifdef SEQ_TX_PARITY_EN
                PAR: begin
                    state_q <= DONE;
                    j_out_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
`endif
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    j_out_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign j_out = j_out_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
